// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Holds the FSM state type, nibble width and index-width helper.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// 4-bit carry-lookahead adder, purely combinational.
// Carries are expanded from generate/propagate terms.
module cla_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] out,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign out = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA over WIDTH/4 cycles.
// Define NSA_SUB_EN to add the op_sub port (a - b mode).
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef NSA_SUB_EN
    input  logic             op_sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = idx_width(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
    end

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             last;
    logic             accept;
    logic             carry_init;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] s_nib;
    logic       c_nib;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == LAST);

    assign a_nib = a_reg[idx*NIBBLE_W +: NIBBLE_W];

`ifdef NSA_SUB_EN
    logic op_sub_reg;
    // Two's complement: invert b per nibble, seed carry with 1.
    assign b_nib      = b_reg[idx*NIBBLE_W +: NIBBLE_W] ^ {4{op_sub_reg}};
    assign carry_init = op_sub ? 1'b1 : cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sub_reg <= 1'b0;
        end else if (accept) begin
            op_sub_reg <= op_sub;
        end
    end
`else
    assign b_nib      = b_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign carry_init = cin;
`endif

    cla_adder u_cla (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .out  (s_nib),
        .cout (c_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= carry_init;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
            carry <= c_nib;
            idx   <= idx + IW'(1);
            if (last) begin
                cout <= c_nib;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16).
// Subtract vectors run only when NSA_SUB_EN is defined.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0] q[$];
    int total = 0;
    int bad = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef NSA_SUB_EN
        .op_sub    (op_sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: pops on each output transfer, checks hold under backpressure.
    bit         held = 1'b0;
    logic [W:0] held_v;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (held) chk("hold_stable", 32'({cout, sum}), 32'(held_v));
            if (out_ready) begin
                held = 1'b0;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_output: got=%h expected=none",
                             {cout, sum});
                end else begin
                    chk("result", 32'({cout, sum}), 32'(q.pop_front()));
                end
            end else begin
                held = 1'b1;
                held_v = {cout, sum};
            end
        end else begin
            held = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts,
                        input logic [W:0] exp);
        int cyc;
        cyc = 0;
        q.push_back(exp);
        in_valid = 1'b1;
        forever begin
            if (in_ready) begin
                a = ta;
                b = tb;
                cin = tc;
                op_sub = ts;
                @(posedge clk);
                #1;
                break;
            end
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            if (rand_rdy) out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got=0 expected=1");
                void'(q.pop_back());
                break;
            end
        end
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_out(output int lat);
        bit irdy_seen;
        irdy_seen = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) irdy_seen = 1'b1;
        end
        chk("in_ready_low_run", 32'(irdy_seen), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cyc;
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic         tc;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum_cout", 32'({cout, sum}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 16'h2345});
        wait_out(lat);
        chk("latency_basic", 32'(lat), 32'd4);

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 16'h0000});
        wait_out(lat);
        chk("latency_ripple", 32'(lat), 32'd4);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 16'h0000});
        wait_out(lat);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h00F0, 16'h0010, 1'b0, 1'b0, {1'b0, 16'h0100});
        wait_out(lat);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sum", 32'({cout, sum}), 32'h00100);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        send(16'h0FFF, 16'h0FF1, 1'b0, 1'b0, {1'b0, 16'h1FF0});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'({cout, sum}), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h0003, 16'h0004, 1'b0, 1'b0, {1'b0, 16'h0007});
        wait_out(lat);
        chk("latency_after_rst", 32'(lat), 32'd4);

`ifdef NSA_SUB_EN
        send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 16'hFFFE});
        send(16'h0007, 16'h0005, 1'b0, 1'b1, {1'b1, 16'h0002});
`endif

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ta = W'($urandom);
            tb = W'($urandom);
            tc = 1'($urandom);
            if (i % 50 == 0) ta = '1;
            send(ta, tb, tc, 1'b0, {1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
